// File: rtl/cc_ben_unit.sv
// rtl/cc_ben_unit.sv - SLC-3 condition-code / branch-enable unit with NZP save stack
module cc_ben_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 4,
    parameter int GATE_OPCODE = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            bus,
    input  logic [15:0]                      ir,
    input  logic                             ld_cc,
    input  logic                             ld_ben,
    input  logic                             cc_push,
    input  logic                             cc_pop,
    input  logic                             err_clr,
    output logic [2:0]                       nzp,
    output logic                             ben,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             stack_err
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [2:0]         stack [STACK_DEPTH];
    logic [2:0]         cls;
    logic               push_ok;
    logic               pop_ok;
    logic               err_evt;
    logic               gate_ok;
    logic               ben_next;
    logic [DEPTH_W-1:0] top;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic               unused_ir;

    assign stack_full  = (depth == DEPTH_W'(STACK_DEPTH));
    assign stack_empty = (depth == '0);
    assign unused_ir   = ^ir[8:0];

    always_comb begin
        cls = 3'b001;
        if (bus[DATA_WIDTH-1]) begin
            cls = 3'b100;
        end else if (bus == '0) begin
            cls = 3'b010;
        end
    end

    // A simultaneous push and pop is treated as a control error: neither takes effect.
    assign push_ok = cc_push && !cc_pop && !stack_full;
    assign pop_ok  = cc_pop && !cc_push && !stack_empty;
    assign err_evt = (cc_push && cc_pop) || (cc_push && stack_full) || (cc_pop && stack_empty);

    assign top    = depth - DEPTH_W'(1);
    assign wr_idx = depth[IDX_W-1:0];
    assign rd_idx = top[IDX_W-1:0];

    assign gate_ok  = (GATE_OPCODE == 0) || (ir[15:12] == 4'b0000);
    assign ben_next = gate_ok && |(ir[11:9] & nzp);

    always_ff @(posedge clk) begin
        if (reset) begin
            nzp       <= 3'b010;
            ben       <= 1'b0;
            depth     <= '0;
            stack_err <= 1'b0;
        end else begin
            if (pop_ok) begin
                nzp <= stack[rd_idx];
            end else if (ld_cc) begin
                nzp <= cls;
            end
            if (ld_ben) begin
                ben <= ben_next;
            end
            if (push_ok) begin
                depth <= depth + DEPTH_W'(1);
            end else if (pop_ok) begin
                depth <= top;
            end
            if (err_evt) begin
                stack_err <= 1'b1;
            end else if (err_clr) begin
                stack_err <= 1'b0;
            end
        end
    end

    // Stack storage is not reset; entries above depth are never read.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            stack[wr_idx] <= nzp;
        end
    end
endmodule
